axis_stream_fifo: RTL and testbench

//  Elastic AXI-Stream buffer between DMA_Controller stream out (sm_*) and accelerator stream in (ss_*).

---
 rtl/axis_stream_fifo.sv | 164 ++++++++++++++++
 tb/tb_axis_stream_fifo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/axis_stream_fifo.sv
// -----------------------------------------------------------------------------
// axis_stream_fifo
//   Elastic AXI-Stream buffer between a DMA stream master and an accelerator
//   stream slave. Word order and tlast boundaries are preserved; fill level,
//   stored end-of-packet count and an almost-full flag are reported for DMA
//   status.
//
// Ports
//   wb_clk_i     in   1        single clock
//   wb_rst_i     in   1        synchronous reset, active-high
//   flush        in   1        synchronous clear of contents (wins over push/pop)
//   s_tvalid     in   1        upstream word valid
//   s_tdata      in   DATA_W   upstream data
//   s_tlast      in   1        upstream end-of-packet
//   s_tready     out  1        FIFO can accept a word this cycle
//   m_tvalid     out  1        head word valid
//   m_tdata      out  DATA_W   head-of-FIFO data (first-word fall-through)
//   m_tlast      out  1        head-of-FIFO tlast
//   m_tready     in   1        downstream accepts the head word
//   level        out  AW+1     words stored
//   pkt_cnt      out  AW+1     stored words carrying tlast=1
//   almost_full  out  1        level >= DEPTH-AF_MARGIN
// -----------------------------------------------------------------------------
module axis_stream_fifo #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 2
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       flush,
    input  logic                       s_tvalid,
    input  logic [DATA_W-1:0]          s_tdata,
    input  logic                       s_tlast,
    output logic                       s_tready,
    output logic                       m_tvalid,
    output logic [DATA_W-1:0]          m_tdata,
    output logic                       m_tlast,
    input  logic                       m_tready,
    output logic [$clog2(DEPTH):0]     level,
    output logic [$clog2(DEPTH):0]     pkt_cnt,
    output logic                       almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] LVL_ZERO  = {LW{1'b0}};
    localparam logic [LW-1:0] LVL_ONE   = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AFULL = LW'(DEPTH - AF_MARGIN);

    // Storage entries carry tlast in the MSB above the data word.
    logic [DATA_W:0]    mem_q [DEPTH];

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic [LW-1:0]      pkt_cnt_q, pkt_cnt_d;
    logic               full_q, full_d;
    logic               m_tvalid_q, m_tvalid_d;
    logic               almost_full_q, almost_full_d;
    logic [DATA_W:0]    head_q, head_d;

    logic               push_s;
    logic               pop_s;

    // full_q is registered so s_tready only depends on state, flush and reset.
    assign s_tready    = ~full_q & ~flush & ~wb_rst_i;
    assign push_s      = s_tvalid & s_tready;
    assign pop_s       = m_tvalid_q & m_tready;

    assign m_tvalid    = m_tvalid_q;
    assign m_tdata     = head_q[DATA_W-1:0];
    assign m_tlast     = head_q[DATA_W];
    assign level       = level_q;
    assign pkt_cnt     = pkt_cnt_q;
    assign almost_full = almost_full_q;

    // Next pointers, level and packet count; flush overrides any handshake.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        pkt_cnt_d = pkt_cnt_q;
        if (flush) begin
            wr_ptr_d  = PTR_ZERO;
            rd_ptr_d  = PTR_ZERO;
            level_d   = LVL_ZERO;
            pkt_cnt_d = LVL_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
            case ({push_s & s_tlast, pop_s & head_q[DATA_W]})
                2'b10:   pkt_cnt_d = pkt_cnt_q + LVL_ONE;
                2'b01:   pkt_cnt_d = pkt_cnt_q - LVL_ONE;
                default: pkt_cnt_d = pkt_cnt_q;
            endcase
        end
    end

    // Next registered head word and status flags derived from the next state.
    always_comb begin
        full_d        = (level_d == LVL_FULL);
        m_tvalid_d    = (level_d != LVL_ZERO);
        almost_full_d = (level_d >= LVL_AFULL);
        head_d        = {(DATA_W+1){1'b0}};
        if (level_d == LVL_ZERO) begin
            head_d = {(DATA_W+1){1'b0}};
        end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
            // The word being written this cycle becomes the new head
            // (FIFO was empty, or its only word is popped at the same time).
            head_d = {s_tlast, s_tdata};
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr_q      <= PTR_ZERO;
            rd_ptr_q      <= PTR_ZERO;
            level_q       <= LVL_ZERO;
            pkt_cnt_q     <= LVL_ZERO;
            full_q        <= 1'b0;
            m_tvalid_q    <= 1'b0;
            almost_full_q <= 1'b0;
            head_q        <= {(DATA_W+1){1'b0}};
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            pkt_cnt_q     <= pkt_cnt_d;
            full_q        <= full_d;
            m_tvalid_q    <= m_tvalid_d;
            almost_full_q <= almost_full_d;
            head_q        <= head_d;
        end
    end

    // Storage array; contents survive flush and reset, only pointers move.
    always_ff @(posedge wb_clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {s_tlast, s_tdata};
        end
    end

endmodule

// File: tb/tb_axis_stream_fifo.sv
// -----------------------------------------------------------------------------
// tb_axis_stream_fifo
//   Directed scenarios followed by a randomized run. A queue of stored words
//   is the reference: handshakes, level, packet count and head word are all
//   derived from that queue every cycle.
// -----------------------------------------------------------------------------
module tb_axis_stream_fifo;

    localparam int DATA_W    = 32;
    localparam int DEPTH     = 8;
    localparam int AF_MARGIN = 2;
    localparam int LW        = $clog2(DEPTH) + 1;

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_i = 1'b1;
    logic              flush    = 1'b0;
    logic              s_tvalid = 1'b0;
    logic [DATA_W-1:0] s_tdata  = '0;
    logic              s_tlast  = 1'b0;
    logic              s_tready;
    logic              m_tvalid;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tlast;
    logic              m_tready = 1'b0;
    logic [LW-1:0]     level;
    logic [LW-1:0]     pkt_cnt;
    logic              almost_full;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference contents: {tlast, data}, head at index 0.
    logic [DATA_W:0] model_q[$];

    axis_stream_fifo #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AF_MARGIN (AF_MARGIN)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .flush       (flush),
        .s_tvalid    (s_tvalid),
        .s_tdata     (s_tdata),
        .s_tlast     (s_tlast),
        .s_tready    (s_tready),
        .m_tvalid    (m_tvalid),
        .m_tdata     (m_tdata),
        .m_tlast     (m_tlast),
        .m_tready    (m_tready),
        .level       (level),
        .pkt_cnt     (pkt_cnt),
        .almost_full (almost_full)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    function automatic int model_pkts();
        int c = 0;
        foreach (model_q[i]) begin
            if (model_q[i][DATA_W]) c++;
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one cycle, check DUT state against the queue before
    // the edge, then advance the queue by the handshakes that occur.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic l,
                        input logic rdy, input logic fl);
        logic exp_rdy;
        logic do_push;
        logic do_pop;
        s_tvalid = v;
        s_tdata  = d;
        s_tlast  = l;
        m_tready = rdy;
        flush    = fl;
        #1;
        exp_rdy = (model_q.size() != DEPTH) && !fl && !wb_rst_i;
        check("s_tready", 64'(s_tready), 64'(exp_rdy));
        check("m_tvalid", 64'(m_tvalid), 64'(model_q.size() != 0));
        check("level", 64'(level), 64'(model_q.size()));
        check("pkt_cnt", 64'(pkt_cnt), 64'(model_pkts()));
        check("almost_full", 64'(almost_full), 64'(model_q.size() >= DEPTH - AF_MARGIN));
        if (model_q.size() != 0) begin
            check("m_tdata", 64'(m_tdata), 64'(model_q[0][DATA_W-1:0]));
            check("m_tlast", 64'(m_tlast), 64'(model_q[0][DATA_W]));
        end
        do_push = v && exp_rdy;
        do_pop  = (model_q.size() != 0) && rdy;
        @(posedge wb_clk_i);
        if (wb_rst_i || fl) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back({l, d});
        end
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (model_q.size() != 0) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        // Bring the DUT out of its undefined power-up state.
        @(posedge wb_clk_i);
        #1;
        step(1'b1, 32'h0000_00FF, 1'b0, 1'b1, 1'b0);
        check("rst_m_tdata", 64'(m_tdata), 64'h0);
        check("rst_m_tlast", 64'(m_tlast), 64'h0);
        check("rst_level", 64'(level), 64'h0);
        wb_rst_i = 1'b0;

        // T1: four words with the sink stalled.
        for (int i = 0; i < 4; i++) step(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0);
        check("t1_level", 64'(level), 64'd4);
        check("t1_m_tdata", 64'(m_tdata), 64'hA0);
        check("t1_s_tready", 64'(s_tready), 64'd1);
        drain();

        // T2: overfill attempt; the ninth word must be refused.
        for (int i = 0; i < 9; i++) step(1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0, 1'b0);
        check("t2_level", 64'(level), 64'd8);
        check("t2_almost_full", 64'(almost_full), 64'd1);
        check("t2_s_tready", 64'(s_tready), 64'd0);
        drain();
        check("t2_drained", 64'(level), 64'd0);

        // T3: steady push+pop at level 3 across pointer wrap, words 0..19.
        for (int i = 0; i < 3; i++) step(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 3; i < 20; i++) begin
            step(1'b1, 32'(i), 1'b0, 1'b1, 1'b0);
            check("t3_level", 64'(level), 64'd3);
        end
        drain();

        // T4: packets of length 2, 1, 3.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'hC0 + 32'(i), (i == 1) || (i == 2) || (i == 5), 1'b0, 1'b0);
        end
        check("t4_pkt_cnt", 64'(pkt_cnt), 64'd3);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("t4_pkt_after_pop", 64'(pkt_cnt), 64'd1);
        check("t4_head_tlast", 64'(m_tlast), 64'd0);
        drain();

        // T5: flush beats a simultaneous push and pop.
        for (int i = 0; i < 5; i++) step(1'b1, 32'hD0 + 32'(i), i == 2, 1'b0, 1'b0);
        step(1'b1, 32'hDD, 1'b1, 1'b1, 1'b1);
        check("t5_level", 64'(level), 64'd0);
        check("t5_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("t5_m_tvalid", 64'(m_tvalid), 64'd0);
        step(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
        check("t5_after_flush", 64'(m_tdata), 64'h77);
        drain();

        // T6: reset in the middle of a packet at level 6.
        for (int i = 0; i < 6; i++) step(1'b1, 32'hE0 + 32'(i), 1'b0, 1'b0, 1'b0);
        wb_rst_i = 1'b1;
        step(1'b1, 32'hEE, 1'b1, 1'b1, 1'b0);
        check("t6_m_tvalid", 64'(m_tvalid), 64'd0);
        check("t6_m_tdata", 64'(m_tdata), 64'h0);
        check("t6_almost_full", 64'(almost_full), 64'd0);
        check("t6_pkt_cnt", 64'(pkt_cnt), 64'd0);
        wb_rst_i = 1'b0;
        step(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
        check("t6_first_word", 64'(m_tdata), 64'h55);
        drain();

        // Randomized traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
